// File: rtl/bus_master_port.sv
// ---------------------------------------------------------------------------
// bus_master_port
//
// Master-side serial bus port. Takes one parallel read/write request, asks
// the arbiter for the bus, then serializes slave ID, address and (for writes)
// data LSB-first on M_DOUT. For reads it collects DATA_WIDTH reply bits from
// S_DIN, sampling only on S_DVALID cycles, and reports them on RSP_RDATA.
//
// Ports
//   CLK, RSTN                 clock (rising edge), async active-low reset
//   REQ_VALID/REQ_READY       request handshake (REQ_READY = port idle)
//   REQ_WE/REQ_SLV/REQ_ADDR/REQ_WDATA  request fields, captured on accept
//   M_BREQ/M_BGRANT           arbiter request / grant
//   M_UTIL/M_ADD/M_DOUT/M_RW  bus-utilised, slave-ID phase, serial bit, r/w
//   S_READY/S_DIN/S_DVALID    slave ready, serial read bit, read bit valid
//   RSP_VALID/RSP_ERR         completion pulse, timeout-abort flag
//   RSP_RDATA                 last completed read data (held)
// ---------------------------------------------------------------------------
module bus_master_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WE,
    input  logic [1:0]            REQ_SLV,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_WDATA,
    output logic                  M_BREQ,
    input  logic                  M_BGRANT,
    output logic                  M_UTIL,
    output logic                  M_ADD,
    output logic                  M_DOUT,
    output logic                  M_RW,
    input  logic                  S_READY,
    input  logic                  S_DIN,
    input  logic                  S_DVALID,
    output logic                  RSP_VALID,
    output logic                  RSP_ERR,
    output logic [DATA_WIDTH-1:0] RSP_RDATA
);

    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW   = $clog2(MAXW) + 1;
    localparam int TW   = $clog2(TIMEOUT) + 1;

    localparam logic [CW-1:0] SID_LAST  = CW'(1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, ARB, SID, WAIT_SLV, ADDR, WDATA, RDATA, DONE
    } state_t;

    state_t                state, state_next;
    logic [CW-1:0]         bit_cnt, bit_cnt_next;
    logic [TW-1:0]         tmo_cnt, tmo_cnt_next;
    logic                  tmo_err, tmo_err_next;
    logic [DATA_WIDTH-1:0] rbuf, rbuf_next;

    // Request shadow registers, loaded on accept
    logic                  we_sh;
    logic [1:0]            slv_sh;
    logic [ADDR_WIDTH-1:0] addr_sh;
    logic [DATA_WIDTH-1:0] wdata_sh;

    logic accept;
    logic breq_next, util_next, add_next, dout_next, rw_next;
    logic rsp_valid_next, rsp_err_next;

    assign REQ_READY = (state == IDLE);
    assign accept    = (state == IDLE) && REQ_VALID;

    // Next-state logic. Outputs are decoded from the *next* state and bit
    // counter so that they can be registered without adding a cycle of lag.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        tmo_cnt_next = tmo_cnt;
        tmo_err_next = tmo_err;
        rbuf_next    = rbuf;

        case (state)
            IDLE: begin
                if (REQ_VALID) begin
                    state_next   = ARB;
                    tmo_err_next = 1'b0;
                    rbuf_next    = '0;
                end
            end
            ARB: begin
                if (M_BGRANT) state_next = SID;
            end
            SID: begin
                if (bit_cnt == SID_LAST) state_next = WAIT_SLV;
                else                     bit_cnt_next = bit_cnt + 1'b1;
            end
            WAIT_SLV: begin
                // A ready slave wins over an expiring timeout in the same cycle
                if (S_READY) begin
                    state_next = ADDR;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_next   = DONE;
                    tmo_err_next = 1'b1;
                end else begin
                    tmo_cnt_next = tmo_cnt + 1'b1;
                end
            end
            ADDR: begin
                if (bit_cnt == ADDR_LAST) state_next = we_sh ? WDATA : RDATA;
                else                      bit_cnt_next = bit_cnt + 1'b1;
            end
            WDATA: begin
                if (bit_cnt == DATA_LAST) state_next = DONE;
                else                      bit_cnt_next = bit_cnt + 1'b1;
            end
            RDATA: begin
                if (S_DVALID) begin
                    rbuf_next = rbuf | (DATA_WIDTH'(S_DIN) << bit_cnt);
                    if (bit_cnt == DATA_LAST) state_next = DONE;
                    else                      bit_cnt_next = bit_cnt + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Every phase starts counting from zero
        if (state_next != state) begin
            bit_cnt_next = '0;
            tmo_cnt_next = '0;
        end

        breq_next      = state_next inside {ARB, SID, WAIT_SLV, ADDR, WDATA, RDATA};
        util_next      = state_next inside {SID, WAIT_SLV, ADDR, WDATA, RDATA};
        add_next       = (state_next == SID);
        rw_next        = util_next && we_sh;
        rsp_valid_next = (state_next == DONE);
        rsp_err_next   = (state_next == DONE) && tmo_err_next;

        // Mask-and-reduce picks the serial bit without leaving unused slice bits
        case (state_next)
            SID:     dout_next = slv_sh[bit_cnt_next[0]];
            ADDR:    dout_next = |(addr_sh & (ADDR_WIDTH'(1) << bit_cnt_next));
            WDATA:   dout_next = |(wdata_sh & (DATA_WIDTH'(1) << bit_cnt_next));
            default: dout_next = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
            tmo_err   <= 1'b0;
            M_BREQ    <= 1'b0;
            M_UTIL    <= 1'b0;
            M_ADD     <= 1'b0;
            M_DOUT    <= 1'b0;
            M_RW      <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_ERR   <= 1'b0;
            RSP_RDATA <= '0;
        end else begin
            state     <= state_next;
            bit_cnt   <= bit_cnt_next;
            tmo_cnt   <= tmo_cnt_next;
            tmo_err   <= tmo_err_next;
            M_BREQ    <= breq_next;
            M_UTIL    <= util_next;
            M_ADD     <= add_next;
            M_DOUT    <= dout_next;
            M_RW      <= rw_next;
            RSP_VALID <= rsp_valid_next;
            RSP_ERR   <= rsp_err_next;
            // Read data becomes visible in the DONE cycle, including the last bit
            if (state == RDATA && state_next == DONE) RSP_RDATA <= rbuf_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            we_sh    <= REQ_WE;
            slv_sh   <= REQ_SLV;
            addr_sh  <= REQ_ADDR;
            wdata_sh <= REQ_WDATA;
        end
        rbuf <= rbuf_next;
    end

endmodule

// File: tb/tb_bus_master_port.sv
// ---------------------------------------------------------------------------
// tb_bus_master_port
//
// Randomized self-checking bench for bus_master_port. For each transaction a
// reference plan is built phase by phase (arbitration, slave ID, wait,
// address, data, done) giving the expected output vector and the stimulus
// for every cycle after accept; the DUT is then stepped and compared.
// ---------------------------------------------------------------------------
module tb_bus_master_port;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          REQ_VALID, REQ_READY, REQ_WE;
    logic [1:0]    REQ_SLV;
    logic [AW-1:0] REQ_ADDR;
    logic [DW-1:0] REQ_WDATA;
    logic          M_BREQ, M_BGRANT, M_UTIL, M_ADD, M_DOUT, M_RW;
    logic          S_READY, S_DIN, S_DVALID;
    logic          RSP_VALID, RSP_ERR;
    logic [DW-1:0] RSP_RDATA;

    bus_master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_SLV(REQ_SLV), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .M_BREQ(M_BREQ), .M_BGRANT(M_BGRANT), .M_UTIL(M_UTIL), .M_ADD(M_ADD),
        .M_DOUT(M_DOUT), .M_RW(M_RW),
        .S_READY(S_READY), .S_DIN(S_DIN), .S_DVALID(S_DVALID),
        .RSP_VALID(RSP_VALID), .RSP_ERR(RSP_ERR), .RSP_RDATA(RSP_RDATA)
    );

    always #5 CLK = ~CLK;

    int            n_vec = 0;
    int            n_err = 0;
    int            txn_id = 0;
    logic [DW-1:0] mdl_rdata = '0;

    // Expected control vector bits:
    // [7] REQ_READY [6] M_BREQ [5] M_UTIL [4] M_ADD [3] M_DOUT
    // [2] M_RW (while M_UTIL) [1] RSP_VALID [0] RSP_ERR
    logic [7:0]    exp_ctl_q[$];
    logic [DW-1:0] exp_rd_q[$];
    logic [3:0]    in_q[$];        // {M_BGRANT, S_READY, S_DVALID, S_DIN}

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic bit_of(input logic [31:0] v, input int i);
        logic [31:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic logic [31:0] observe();
        return 32'({RSP_RDATA, REQ_READY, M_BREQ, M_UTIL, M_ADD, M_DOUT,
                    M_RW & M_UTIL, RSP_VALID, RSP_ERR});
    endfunction

    function automatic logic [31:0] expect_vec(input logic [7:0] ctl, input logic [DW-1:0] rd);
        return 32'({rd, ctl});
    endfunction

    task automatic push(input logic [7:0] ctl, input logic [3:0] inp);
        exp_ctl_q.push_back(ctl);
        exp_rd_q.push_back(mdl_rdata);
        in_q.push_back(inp);
    endtask

    task automatic scramble_req(input logic hold);
        REQ_VALID = hold ? 1'b1 : rb();
        REQ_WE    = rb();
        REQ_SLV   = 2'($urandom);
        REQ_ADDR  = AW'($urandom);
        REQ_WDATA = DW'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            chk("idle", observe(), expect_vec(8'h80, mdl_rdata));
            REQ_VALID = 1'b0;
            M_BGRANT  = rb();
            S_READY   = rb();
            S_DVALID  = rb();
            S_DIN     = rb();
        end
    endtask

    // gd: ARB cycles before grant; rd: WAIT_SLV cycles before S_READY;
    // tmo: slave never ready; hold: REQ_VALID kept high with junk fields;
    // abort_at: cycle after accept at which RSTN is pulled (0 = never).
    task automatic run_txn(input logic we, input logic [1:0] slv, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                           input int gd, input int rd, input logic tmo,
                           input logic hold, input int abort_at);
        int nw;
        int nv;
        logic dv;
        logic din;
        txn_id++;

        // cycle 0: idle, request presented and accepted
        @(posedge CLK); #1;
        chk($sformatf("t%0d accept", txn_id), observe(), expect_vec(8'h80, mdl_rdata));
        REQ_VALID = 1'b1;
        REQ_WE    = we;
        REQ_SLV   = slv;
        REQ_ADDR  = addr;
        REQ_WDATA = wdata;
        M_BGRANT  = rb();
        S_READY   = rb();
        S_DVALID  = rb();
        S_DIN     = rb();

        // reference plan
        for (int i = 0; i <= gd; i++)
            push({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, {i == gd, rb(), rb(), rb()});
        for (int i = 0; i < 2; i++)
            push({1'b0, 1'b1, 1'b1, 1'b1, bit_of(32'(slv), i), we, 1'b0, 1'b0},
                 {rb(), rb(), rb(), rb()});
        nw = tmo ? TO : rd + 1;
        for (int i = 0; i < nw; i++)
            push({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, we, 1'b0, 1'b0},
                 {rb(), !tmo && (i == rd), rb(), rb()});
        if (!tmo) begin
            for (int i = 0; i < AW; i++)
                push({1'b0, 1'b1, 1'b1, 1'b0, bit_of(32'(addr), i), we, 1'b0, 1'b0},
                     {rb(), rb(), rb(), rb()});
            if (we) begin
                for (int i = 0; i < DW; i++)
                    push({1'b0, 1'b1, 1'b1, 1'b0, bit_of(32'(wdata), i), we, 1'b0, 1'b0},
                         {rb(), rb(), rb(), rb()});
            end else begin
                nv = 0;
                while (nv < DW) begin
                    dv  = ($urandom_range(0, 2) != 0);
                    din = dv ? bit_of(32'(rdata), nv) : rb();
                    push({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, we, 1'b0, 1'b0}, {rb(), rb(), dv, din});
                    if (dv) nv++;
                end
                mdl_rdata = rdata;
            end
        end
        push({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, tmo}, {rb(), rb(), rb(), rb()});

        for (int k = 0; k < exp_ctl_q.size(); k++) begin
            @(posedge CLK); #1;
            chk($sformatf("t%0d c%0d", txn_id, k + 1), observe(),
                expect_vec(exp_ctl_q[k], exp_rd_q[k]));
            {M_BGRANT, S_READY, S_DVALID, S_DIN} = in_q[k];
            scramble_req(hold);
            if (k + 1 == abort_at) begin
                #3 RSTN = 1'b0;
                mdl_rdata = '0;
                #1 chk($sformatf("t%0d rst-async", txn_id), observe(), expect_vec(8'h80, '0));
                REQ_VALID = 1'b0;
                {M_BGRANT, S_READY, S_DVALID, S_DIN} = 4'b0;
                for (int j = 0; j < 2; j++) begin
                    @(posedge CLK); #1;
                    chk($sformatf("t%0d rst-hold", txn_id), observe(), expect_vec(8'h80, '0));
                end
                @(negedge CLK) RSTN = 1'b1;
                break;
            end
        end
        exp_ctl_q.delete();
        exp_rd_q.delete();
        in_q.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_SLV = '0; REQ_ADDR = '0; REQ_WDATA = '0;
        M_BGRANT = 1'b0; S_READY = 1'b0; S_DIN = 1'b0; S_DVALID = 1'b0;
        repeat (2) @(posedge CLK);
        #1 chk("reset", observe(), expect_vec(8'h80, '0));
        @(negedge CLK) RSTN = 1'b1;
        idle(2);

        // write, immediate grant and ready: done 25 cycles after accept
        run_txn(1'b1, 2'd2, 12'hA5C, 8'h3C, 8'h00, 0, 0, 1'b0, 1'b0, 0);
        idle(1);
        // read with S_DVALID gaps
        run_txn(1'b0, 2'd3, 12'h123, 8'h00, 8'hB7, 1, 2, 1'b0, 1'b0, 0);
        // slave never ready: timeout abort, read data held
        run_txn(1'b1, 2'd1, 12'hFFF, 8'hFF, 8'h00, 0, 0, 1'b1, 1'b0, 0);
        run_txn(1'b0, 2'd1, 12'h001, 8'h00, 8'h5A, 0, 0, 1'b1, 1'b0, 0);
        // ready on the last permitted WAIT_SLV cycle
        run_txn(1'b0, 2'd0, 12'h800, 8'h00, 8'h81, 0, TO - 1, 1'b0, 1'b0, 0);
        // grant delayed 5 cycles while REQ_VALID stays high
        run_txn(1'b1, 2'd1, 12'h3C5, 8'hA6, 8'h00, 5, 0, 1'b0, 1'b1, 0);
        idle(1);
        // reset in the middle of the address phase, then a normal request
        run_txn(1'b1, 2'd2, 12'h5A5, 8'h99, 8'h00, 0, 0, 1'b0, 1'b0, 8);
        run_txn(1'b0, 2'd2, 12'h0F0, 8'h00, 8'h6E, 0, 1, 1'b0, 1'b0, 0);
        // back-to-back writes with REQ_VALID held high
        run_txn(1'b1, 2'd1, 12'h111, 8'h11, 8'h00, 0, 0, 1'b0, 1'b1, 0);
        run_txn(1'b1, 2'd2, 12'h222, 8'h22, 8'h00, 0, 0, 1'b0, 1'b1, 0);
        run_txn(1'b1, 2'd3, 12'h333, 8'h33, 8'h00, 0, 0, 1'b0, 1'b1, 0);

        for (int t = 0; t < 120; t++) begin
            if (rb()) idle($urandom_range(1, 3));
            run_txn(rb(), 2'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
                    $urandom_range(0, 6), $urandom_range(0, TO - 1),
                    ($urandom_range(0, 7) == 0), rb(), 0);
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
